// File: rtl/lvt_read_port.sv
`default_nettype none
// ============================================================================
// Module   : lvt_read_port
// Function : LVT multiport-memory read side: live-bank lookup, broadcast bank
//            read, live-word select and a 2-entry valid/ready output buffer.
// Revision : 1.0
// ============================================================================
module lvt_read_port #(
    parameter int INDEX_WIDTH = 8,
    parameter int R           = 4,
    parameter int N_BITS_R    = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  upd_en,
    input  logic [2*INDEX_WIDTH-1:0]    upd_addr,
    input  logic [2*N_BITS_R-1:0]       upd_bank,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [INDEX_WIDTH-1:0]      rd_addr,
    output logic                        bank_rd_en,
    output logic [INDEX_WIDTH-1:0]      bank_rd_addr,
    input  logic [R*DATA_WIDTH-1:0]     bank_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [N_BITS_R-1:0]         out_bank
);

    localparam int DEPTH = 2**INDEX_WIDTH;

    logic [N_BITS_R-1:0]    r_lvt [DEPTH];
    logic                   r_s1_valid;
    logic [N_BITS_R-1:0]    r_s1_bank;
    logic [DATA_WIDTH-1:0]  r_buf_data [2];
    logic [N_BITS_R-1:0]    r_buf_bank [2];
    logic                   r_wptr;
    logic                   r_rptr;
    logic [1:0]             r_occ;

    logic [INDEX_WIDTH-1:0] w_upd_addr0;
    logic [INDEX_WIDTH-1:0] w_upd_addr1;
    logic [N_BITS_R-1:0]    w_upd_bank0;
    logic [N_BITS_R-1:0]    w_upd_bank1;
    logic [N_BITS_R-1:0]    w_sel_bank;
    logic [DATA_WIDTH-1:0]  w_cap_data;
    logic [2:0]             w_credit;
    logic                   w_pop;
    logic                   w_accept;

    assign w_upd_addr0 = upd_addr[0 +: INDEX_WIDTH];
    assign w_upd_addr1 = upd_addr[INDEX_WIDTH +: INDEX_WIDTH];
    assign w_upd_bank0 = upd_bank[0 +: N_BITS_R];
    assign w_upd_bank1 = upd_bank[N_BITS_R +: N_BITS_R];

    // Same-cycle updates override the stored entry; port 1 has priority.
    always_comb begin
        w_sel_bank = r_lvt[rd_addr];
        if (upd_en[1] && (w_upd_addr1 == rd_addr)) begin
            w_sel_bank = w_upd_bank1;
        end else if (upd_en[0] && (w_upd_addr0 == rd_addr)) begin
            w_sel_bank = w_upd_bank0;
        end
    end

    // Credit counts the S1 word already in flight so capture can never overflow.
    assign out_valid    = (r_occ != 2'd0);
    assign w_pop        = out_valid & out_ready;
    assign w_credit     = {1'b0, r_occ} + {2'b00, r_s1_valid} - {2'b00, w_pop};
    assign rd_ready     = (w_credit < 3'd2);
    assign w_accept     = rd_valid & rd_ready & ~reset;
    assign bank_rd_en   = w_accept;
    assign bank_rd_addr = w_accept ? rd_addr : '0;
    assign w_cap_data   = bank_rd_data[r_s1_bank*DATA_WIDTH +: DATA_WIDTH];
    assign out_data     = r_buf_data[r_rptr];
    assign out_bank     = r_buf_bank[r_rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_lvt[i] <= '0;
            end
        end else begin
            if (upd_en[0]) r_lvt[w_upd_addr0] <= w_upd_bank0;
            if (upd_en[1]) r_lvt[w_upd_addr1] <= w_upd_bank1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_bank  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) r_s1_bank <= w_sel_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_bank[0] <= '0;
            r_buf_bank[1] <= '0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
            r_occ         <= 2'd0;
        end else begin
            if (r_s1_valid) begin
                r_buf_data[r_wptr] <= w_cap_data;
                r_buf_bank[r_wptr] <= r_s1_bank;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_occ <= w_credit[1:0];
        end
    end

endmodule
`default_nettype wire
